mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width of both requesters and the memory port.
REQ-002 SHALL have parameter DATA_W, default 32, data width of both requesters and the memory port.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port if_req  input  1  fetch read request; held with if_addr until if_ready.
REQ-006 SHALL have port if_addr  input  ADDR_W  fetch byte address.
REQ-007 SHALL have port if_ready  output  1  fetch request accepted this cycle.
REQ-008 SHALL have port if_rvalid  output  1  fetch read data valid.
REQ-009 SHALL have port if_rdata  output  DATA_W  fetch read data.
REQ-010 SHALL have port if_err  output  1  fetch misaligned-address error pulse.
REQ-011 SHALL have port d_req  input  1  data request; held with d_we, d_addr and d_wdata until d_ready.
REQ-012 SHALL have port d_we  input  1  1 = store, 0 = load.
REQ-013 SHALL have port d_addr  input  ADDR_W  data byte address.
REQ-014 SHALL have port d_wdata  input  DATA_W  store data.
REQ-015 SHALL have port d_ready  output  1  data request accepted this cycle.
REQ-016 SHALL have port d_rvalid  output  1  load data valid.
REQ-017 SHALL have port d_rdata  output  DATA_W  load data.
REQ-018 SHALL have port d_err  output  1  data misaligned-address error pulse.
REQ-019 SHALL have port mem_en  output  1  memory access strobe.
REQ-020 SHALL have port mem_we  output  1  memory write enable, qualified by mem_en.
REQ-021 SHALL have port mem_addr  output  ADDR_W  memory byte address.
REQ-022 SHALL have port mem_wdata  output  DATA_W  memory write data.
REQ-023 SHALL have port mem_rdata  input  DATA_W  memory read data, valid exactly 1 cycle after a read strobe.

Function
REQ-024 SHALL accept at most one request per cycle, and SHALL set exactly one of if_ready and d_ready combinationally in an accept cycle.
REQ-025 SHALL accept the only asserted request when exactly one of if_req and d_req is high.
REQ-026 SHALL arbitrate simultaneous requests round-robin: a 1-bit pointer names the preferred port, grants that port, and flips to the other port after any granted access.
REQ-027 SHALL accept a new request every cycle, including the response cycle of a previous read, with no idle cycles.
REQ-028 SHALL, for an aligned accepted request (addr[1:0]==0), drive mem_en=1, mem_addr=granted address and mem_we=d_we for the data port or 0 for the fetch port in the accept cycle.
REQ-029 SHALL drive mem_wdata=d_wdata in every cycle.
REQ-030 SHALL, for a misaligned accepted request, assert ready, keep mem_en=0, and pulse the port's err for exactly one cycle starting on the next cycle, with no rvalid.
REQ-031 SHALL, when no request is accepted, drive mem_en=0 and mem_we=0.
REQ-032 SHALL register the accepting port and the read type, and pulse that port's rvalid for exactly one cycle on the cycle after an aligned read accept; stores SHALL produce no rvalid.
REQ-033 SHALL drive the port's rdata=mem_rdata in its rvalid cycle, capture that value into a per-port hold register, and otherwise output the hold register value.
REQ-034 SHALL never assert if_rvalid and d_rvalid in the same cycle, nor rvalid and err on the same port.

Reset
REQ-035 SHALL, while reset is high, immediately clear the rvalid and err flags, the pending-read tracking, and the rdata hold registers to 0, and set the pointer to prefer the data port.
REQ-036 SHALL, while reset is high, force mem_en, mem_we, if_ready and d_ready to 0 regardless of requests, and SHALL discard any read in flight when reset is asserted.

Verification
REQ-037 SHALL verify a single fetch: if_req, if_addr=0x10, mem_rdata=0xDEADBEEF next cycle -> mem_en/if_ready at cycle 0, if_rvalid=1 and if_rdata=0xDEADBEEF at cycle 1, if_rdata held afterwards.
REQ-038 SHALL verify a conflict after reset: both requests held 2 cycles -> data port granted at cycle 0, fetch at cycle 1, d_rvalid at cycle 1, if_rvalid at cycle 2.
REQ-039 SHALL verify a store: d_we=1, d_addr=0x8, d_wdata=0x1234 -> mem_en=1, mem_we=1, mem_addr=0x8, mem_wdata=0x1234 in the accept cycle, with no d_rvalid.
REQ-040 SHALL verify a misaligned fetch: if_addr=0x6 -> if_ready=1 and mem_en=0 at cycle 0, if_err=1 at cycle 1, if_rvalid=0.
REQ-041 SHALL verify back-to-back loads: d_req continuous with addresses 0x0 and 0x4 -> two accepts in consecutive cycles and two consecutive d_rvalid pulses with the matching data.
REQ-042 SHALL verify reset mid-read: reset asserted in the cycle after a read accept -> rvalid=0 at once, and after release the first conflict grants the data port.

Source files
------------

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter_if
//  Description : Bundle of the two requester ports (fetch and data) and the
//                single memory port served by mem_arbiter.
//  Ports       : fetch  - if_req/if_addr in, if_ready/if_rvalid/if_rdata/if_err out
//                data   - d_req/d_we/d_addr/d_wdata in,
//                         d_ready/d_rvalid/d_rdata/d_err out
//                memory - mem_en/mem_we/mem_addr/mem_wdata out, mem_rdata in
//  Modports    : master - the side that issues requests and models the memory
//                slave  - the arbiter itself
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Fetch requester
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ready;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic              if_err;

    // Data requester
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ready;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    logic              d_err;

    // Memory port
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output if_req, if_addr,
        input  if_ready, if_rvalid, if_rdata, if_err,
        output d_req, d_we, d_addr, d_wdata,
        input  d_ready, d_rvalid, d_rdata, d_err,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

    modport slave (
        input  if_req, if_addr,
        output if_ready, if_rvalid, if_rdata, if_err,
        input  d_req, d_we, d_addr, d_wdata,
        output d_ready, d_rvalid, d_rdata, d_err,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Two-port (fetch / data) arbiter in front of one single-cycle
//                memory. One request is accepted per cycle; simultaneous
//                requests are served round-robin. Reads return one cycle after
//                acceptance, misaligned requests are acknowledged and answered
//                with a one-cycle error pulse instead of a memory access.
//  Ports       : clk   - clock, rising edge
//                reset - asynchronous, active-high
//                bus   - mem_arbiter_if.slave (fetch, data and memory ports)
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  wire logic    clk,
    input  wire logic    reset,
    mem_arbiter_if.slave bus
);

    // Round-robin pointer encoding: names the port preferred on a conflict.
    localparam logic C_PTR_FETCH = 1'b0;
    localparam logic C_PTR_DATA  = 1'b1;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic              ptr_q,       ptr_d;
    logic              if_rvalid_q, if_rvalid_d;
    logic              d_rvalid_q,  d_rvalid_d;
    logic              if_err_q,    if_err_d;
    logic              d_err_q,     d_err_d;
    logic [DATA_W-1:0] if_hold_q,   if_hold_d;
    logic [DATA_W-1:0] d_hold_q,    d_hold_d;

    // ------------------------------------------------------------------------
    // Combinational grant / address selection
    // ------------------------------------------------------------------------
    logic              w_grant_if;
    logic              w_grant_d;
    logic              w_accept;
    logic              w_misalign;
    logic [ADDR_W-1:0] w_addr;

    always_comb begin
        w_grant_if = 1'b0;
        w_grant_d  = 1'b0;
        // Reset blocks every grant so nothing reaches memory while it is held.
        if (!reset) begin
            if (bus.if_req && bus.d_req) begin
                w_grant_d  = (ptr_q == C_PTR_DATA);
                w_grant_if = (ptr_q != C_PTR_DATA);
            end else begin
                w_grant_d  = bus.d_req;
                w_grant_if = bus.if_req;
            end
        end
        w_accept   = w_grant_if | w_grant_d;
        w_addr     = w_grant_d ? bus.d_addr : bus.if_addr;
        w_misalign = (w_addr[1:0] != 2'b00);
    end

    // ------------------------------------------------------------------------
    // Requester handshake and memory strobes
    // ------------------------------------------------------------------------
    assign bus.if_ready  = w_grant_if;
    assign bus.d_ready   = w_grant_d;

    // A misaligned request is acknowledged but never touches memory.
    assign bus.mem_en    = w_accept & ~w_misalign;
    assign bus.mem_we    = w_grant_d & bus.d_we & ~w_misalign;
    assign bus.mem_addr  = w_addr;
    assign bus.mem_wdata = bus.d_wdata;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        ptr_d       = ptr_q;
        if_rvalid_d = 1'b0;
        d_rvalid_d  = 1'b0;
        if_err_d    = 1'b0;
        d_err_d     = 1'b0;
        if_hold_d   = if_hold_q;
        d_hold_d    = d_hold_q;

        // Any granted access, aligned or not, hands priority to the other port.
        if (w_grant_d) begin
            ptr_d = C_PTR_FETCH;
        end else if (w_grant_if) begin
            ptr_d = C_PTR_DATA;
        end

        // Fetches are always reads; data-port reads are loads only.
        if_rvalid_d = w_grant_if & ~w_misalign;
        d_rvalid_d  = w_grant_d  & ~w_misalign & ~bus.d_we;
        if_err_d    = w_grant_if &  w_misalign;
        d_err_d     = w_grant_d  &  w_misalign;

        // Capture the returned word so rdata stays stable after the pulse.
        if (if_rvalid_q) begin
            if_hold_d = bus.mem_rdata;
        end
        if (d_rvalid_q) begin
            d_hold_d = bus.mem_rdata;
        end
    end

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q       <= C_PTR_DATA;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            if_err_q    <= 1'b0;
            d_err_q     <= 1'b0;
            if_hold_q   <= '0;
            d_hold_q    <= '0;
        end else begin
            ptr_q       <= ptr_d;
            if_rvalid_q <= if_rvalid_d;
            d_rvalid_q  <= d_rvalid_d;
            if_err_q    <= if_err_d;
            d_err_q     <= d_err_d;
            if_hold_q   <= if_hold_d;
            d_hold_q    <= d_hold_d;
        end
    end

    // ------------------------------------------------------------------------
    // Response outputs: live memory data in the valid cycle, held value after.
    // ------------------------------------------------------------------------
    assign bus.if_rvalid = if_rvalid_q;
    assign bus.d_rvalid  = d_rvalid_q;
    assign bus.if_err    = if_err_q;
    assign bus.d_err     = d_err_q;
    assign bus.if_rdata  = if_rvalid_q ? bus.mem_rdata : if_hold_q;
    assign bus.d_rdata   = d_rvalid_q  ? bus.mem_rdata : d_hold_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Self-checking bench for mem_arbiter: directed scenarios plus
//                randomized traffic against a transaction-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Memory contents as a pure function of address; 0x10 holds a known word.
    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a == 32'h10) return 32'hDEADBEEF;
        return {~a[15:0], a[15:0]} ^ 32'h5A5A_3C3C;
    endfunction

    // Single-cycle memory: data one cycle after a read strobe, noise otherwise.
    always @(posedge clk) begin
        if (bus.mem_en && !bus.mem_we) bus.mem_rdata <= mem_fn(bus.mem_addr);
        else                           bus.mem_rdata <= $urandom;
    end

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_idle;
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = $urandom_range(0, 63) * 4;
        if ($urandom_range(0, 5) == 0) a = a + $urandom_range(1, 3);
        return a;
    endfunction

    // ------------------------------------------------------------------------
    task automatic test_reset;
        reset = 1'b1;
        bus.if_req = 1'b1; bus.if_addr = 32'h10;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h20; bus.d_wdata = 32'h55;
        #1;
        n_cmp++; if (bus.if_ready !== 1'b0) begin n_bad++; $display("FAIL rst_if_ready got=%b want=0", bus.if_ready); end
        n_cmp++; if (bus.d_ready !== 1'b0) begin n_bad++; $display("FAIL rst_d_ready got=%b want=0", bus.d_ready); end
        n_cmp++; if (bus.mem_en !== 1'b0) begin n_bad++; $display("FAIL rst_mem_en got=%b want=0", bus.mem_en); end
        n_cmp++; if (bus.mem_we !== 1'b0) begin n_bad++; $display("FAIL rst_mem_we got=%b want=0", bus.mem_we); end
        @(negedge clk);
        n_cmp++; if ({bus.if_rvalid, bus.d_rvalid, bus.if_err, bus.d_err} !== 4'b0) begin n_bad++; $display("FAIL rst_flags got=%b want=0000", {bus.if_rvalid, bus.d_rvalid, bus.if_err, bus.d_err}); end
        n_cmp++; if (bus.if_rdata !== 32'h0) begin n_bad++; $display("FAIL rst_if_rdata got=%h want=0", bus.if_rdata); end
        n_cmp++; if (bus.d_rdata !== 32'h0) begin n_bad++; $display("FAIL rst_d_rdata got=%h want=0", bus.d_rdata); end
        n_cmp++; if (bus.mem_en !== 1'b0) begin n_bad++; $display("FAIL rst_mem_en2 got=%b want=0", bus.mem_en); end
        reset = 1'b0;
        drive_idle();
        tick();
    endtask

    task automatic test_single_fetch;
        bus.if_req = 1'b1; bus.if_addr = 32'h10;
        #1;
        n_cmp++; if (bus.if_ready !== 1'b1) begin n_bad++; $display("FAIL fetch_ready got=%b want=1", bus.if_ready); end
        n_cmp++; if (bus.d_ready !== 1'b0) begin n_bad++; $display("FAIL fetch_d_ready got=%b want=0", bus.d_ready); end
        n_cmp++; if (bus.mem_en !== 1'b1) begin n_bad++; $display("FAIL fetch_mem_en got=%b want=1", bus.mem_en); end
        n_cmp++; if (bus.mem_we !== 1'b0) begin n_bad++; $display("FAIL fetch_mem_we got=%b want=0", bus.mem_we); end
        n_cmp++; if (bus.mem_addr !== 32'h10) begin n_bad++; $display("FAIL fetch_mem_addr got=%h want=10", bus.mem_addr); end
        tick();
        bus.if_req = 1'b0;
        #1;
        n_cmp++; if (bus.if_rvalid !== 1'b1) begin n_bad++; $display("FAIL fetch_rvalid got=%b want=1", bus.if_rvalid); end
        n_cmp++; if (bus.if_rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL fetch_rdata got=%h want=deadbeef", bus.if_rdata); end
        n_cmp++; if (bus.if_err !== 1'b0) begin n_bad++; $display("FAIL fetch_err got=%b want=0", bus.if_err); end
        tick();
        n_cmp++; if (bus.if_rvalid !== 1'b0) begin n_bad++; $display("FAIL fetch_rvalid_end got=%b want=0", bus.if_rvalid); end
        n_cmp++; if (bus.if_rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL fetch_rdata_hold got=%h want=deadbeef", bus.if_rdata); end
    endtask

    task automatic test_conflict;
        reset = 1'b1; #1; reset = 1'b0;
        bus.if_req = 1'b1; bus.if_addr = 32'h30;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h20;
        #1;
        n_cmp++; if ({bus.d_ready, bus.if_ready} !== 2'b10) begin n_bad++; $display("FAIL conf_c0_ready got=%b want=10", {bus.d_ready, bus.if_ready}); end
        n_cmp++; if (bus.mem_addr !== 32'h20) begin n_bad++; $display("FAIL conf_c0_addr got=%h want=20", bus.mem_addr); end
        tick();
        #1;
        n_cmp++; if ({bus.d_ready, bus.if_ready} !== 2'b01) begin n_bad++; $display("FAIL conf_c1_ready got=%b want=01", {bus.d_ready, bus.if_ready}); end
        n_cmp++; if (bus.mem_addr !== 32'h30) begin n_bad++; $display("FAIL conf_c1_addr got=%h want=30", bus.mem_addr); end
        n_cmp++; if (bus.d_rvalid !== 1'b1) begin n_bad++; $display("FAIL conf_c1_d_rvalid got=%b want=1", bus.d_rvalid); end
        n_cmp++; if (bus.d_rdata !== mem_fn(32'h20)) begin n_bad++; $display("FAIL conf_c1_d_rdata got=%h want=%h", bus.d_rdata, mem_fn(32'h20)); end
        tick();
        drive_idle();
        #1;
        n_cmp++; if ({bus.if_rvalid, bus.d_rvalid} !== 2'b10) begin n_bad++; $display("FAIL conf_c2_rvalid got=%b want=10", {bus.if_rvalid, bus.d_rvalid}); end
        n_cmp++; if (bus.if_rdata !== mem_fn(32'h30)) begin n_bad++; $display("FAIL conf_c2_if_rdata got=%h want=%h", bus.if_rdata, mem_fn(32'h30)); end
        tick();
    endtask

    task automatic test_store;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h8; bus.d_wdata = 32'h1234;
        #1;
        n_cmp++; if (bus.d_ready !== 1'b1) begin n_bad++; $display("FAIL store_ready got=%b want=1", bus.d_ready); end
        n_cmp++; if ({bus.mem_en, bus.mem_we} !== 2'b11) begin n_bad++; $display("FAIL store_en_we got=%b want=11", {bus.mem_en, bus.mem_we}); end
        n_cmp++; if (bus.mem_addr !== 32'h8) begin n_bad++; $display("FAIL store_addr got=%h want=8", bus.mem_addr); end
        n_cmp++; if (bus.mem_wdata !== 32'h1234) begin n_bad++; $display("FAIL store_wdata got=%h want=1234", bus.mem_wdata); end
        tick();
        drive_idle();
        #1;
        n_cmp++; if ({bus.d_rvalid, bus.d_err} !== 2'b00) begin n_bad++; $display("FAIL store_no_rvalid got=%b want=00", {bus.d_rvalid, bus.d_err}); end
        tick();
    endtask

    task automatic test_misaligned;
        bus.if_req = 1'b1; bus.if_addr = 32'h6;
        #1;
        n_cmp++; if (bus.if_ready !== 1'b1) begin n_bad++; $display("FAIL mis_ready got=%b want=1", bus.if_ready); end
        n_cmp++; if (bus.mem_en !== 1'b0) begin n_bad++; $display("FAIL mis_mem_en got=%b want=0", bus.mem_en); end
        tick();
        drive_idle();
        #1;
        n_cmp++; if ({bus.if_err, bus.if_rvalid} !== 2'b10) begin n_bad++; $display("FAIL mis_err got=%b want=10", {bus.if_err, bus.if_rvalid}); end
        tick();
        n_cmp++; if (bus.if_err !== 1'b0) begin n_bad++; $display("FAIL mis_err_end got=%b want=0", bus.if_err); end
    endtask

    task automatic test_back_to_back;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h0;
        #1;
        n_cmp++; if (bus.d_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready0 got=%b want=1", bus.d_ready); end
        tick();
        bus.d_addr = 32'h4;
        #1;
        n_cmp++; if (bus.d_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready1 got=%b want=1", bus.d_ready); end
        n_cmp++; if (bus.mem_addr !== 32'h4) begin n_bad++; $display("FAIL b2b_addr1 got=%h want=4", bus.mem_addr); end
        n_cmp++; if (bus.d_rvalid !== 1'b1) begin n_bad++; $display("FAIL b2b_rvalid0 got=%b want=1", bus.d_rvalid); end
        n_cmp++; if (bus.d_rdata !== mem_fn(32'h0)) begin n_bad++; $display("FAIL b2b_rdata0 got=%h want=%h", bus.d_rdata, mem_fn(32'h0)); end
        tick();
        drive_idle();
        #1;
        n_cmp++; if (bus.d_rvalid !== 1'b1) begin n_bad++; $display("FAIL b2b_rvalid1 got=%b want=1", bus.d_rvalid); end
        n_cmp++; if (bus.d_rdata !== mem_fn(32'h4)) begin n_bad++; $display("FAIL b2b_rdata1 got=%h want=%h", bus.d_rdata, mem_fn(32'h4)); end
        tick();
        n_cmp++; if (bus.d_rvalid !== 1'b0) begin n_bad++; $display("FAIL b2b_rvalid_end got=%b want=0", bus.d_rvalid); end
        n_cmp++; if (bus.d_rdata !== mem_fn(32'h4)) begin n_bad++; $display("FAIL b2b_rdata_hold got=%h want=%h", bus.d_rdata, mem_fn(32'h4)); end
    endtask

    task automatic test_reset_mid_read;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h40;
        tick();
        drive_idle();
        n_cmp++; if (bus.d_rvalid !== 1'b1) begin n_bad++; $display("FAIL rmr_rvalid_pre got=%b want=1", bus.d_rvalid); end
        reset = 1'b1;
        bus.if_req = 1'b1; bus.if_addr = 32'h50;
        bus.d_req = 1'b1; bus.d_addr = 32'h60;
        #1;
        n_cmp++; if (bus.d_rvalid !== 1'b0) begin n_bad++; $display("FAIL rmr_rvalid got=%b want=0", bus.d_rvalid); end
        n_cmp++; if (bus.d_rdata !== 32'h0) begin n_bad++; $display("FAIL rmr_rdata got=%h want=0", bus.d_rdata); end
        n_cmp++; if ({bus.if_ready, bus.d_ready, bus.mem_en} !== 3'b000) begin n_bad++; $display("FAIL rmr_gated got=%b want=000", {bus.if_ready, bus.d_ready, bus.mem_en}); end
        tick();
        reset = 1'b0;
        #1;
        n_cmp++; if ({bus.d_ready, bus.if_ready} !== 2'b10) begin n_bad++; $display("FAIL rmr_first_grant got=%b want=10", {bus.d_ready, bus.if_ready}); end
        tick();
        drive_idle();
        tick();
    endtask

    // Randomized traffic against a transaction-level model of the rules:
    // requests stay pending until granted, conflicts alternate, reads answer
    // one cycle later, misaligned requests answer with an error pulse.
    task automatic test_random(input int n_cycles);
        logic        pend_if = 1'b0, pend_d = 1'b0, d_wr = 1'b0;
        logic [31:0] if_a = '0, d_a = '0, d_wd = '0, ga;
        logic        pref_data = 1'b1;
        logic        g_if, g_d, aligned;
        logic        e_if_rv = 1'b0, e_d_rv = 1'b0, e_if_err = 1'b0, e_d_err = 1'b0;
        logic [31:0] e_if_data = '0, e_d_data = '0, hold_if = '0, hold_d = '0;
        drive_idle();
        reset = 1'b1; #1; reset = 1'b0;
        for (int c = 0; c < n_cycles; c++) begin
            if (!pend_if && $urandom_range(0, 3) != 0) begin pend_if = 1'b1; if_a = rand_addr(); end
            if (!pend_d && $urandom_range(0, 3) != 0) begin
                pend_d = 1'b1; d_a = rand_addr(); d_wr = 1'($urandom_range(0, 1)); d_wd = $urandom;
            end
            bus.if_req = pend_if; bus.if_addr = if_a;
            bus.d_req = pend_d; bus.d_we = d_wr; bus.d_addr = d_a; bus.d_wdata = d_wd;
            #1;
            g_d     = pend_d && (!pend_if || pref_data);
            g_if    = pend_if && !g_d;
            ga      = g_d ? d_a : if_a;
            aligned = (ga % 4) == 0;
            n_cmp++; if ({bus.if_ready, bus.d_ready} !== {g_if, g_d}) begin n_bad++; $display("FAIL rnd_ready c=%0d got=%b want=%b", c, {bus.if_ready, bus.d_ready}, {g_if, g_d}); end
            n_cmp++; if (bus.mem_en !== ((g_if || g_d) && aligned)) begin n_bad++; $display("FAIL rnd_mem_en c=%0d got=%b want=%b", c, bus.mem_en, (g_if || g_d) && aligned); end
            n_cmp++; if (bus.mem_we !== (g_d && d_wr && aligned)) begin n_bad++; $display("FAIL rnd_mem_we c=%0d got=%b want=%b", c, bus.mem_we, g_d && d_wr && aligned); end
            if ((g_if || g_d) && aligned) begin
                n_cmp++; if (bus.mem_addr !== ga) begin n_bad++; $display("FAIL rnd_mem_addr c=%0d got=%h want=%h", c, bus.mem_addr, ga); end
            end
            n_cmp++; if (bus.mem_wdata !== d_wd) begin n_bad++; $display("FAIL rnd_mem_wdata c=%0d got=%h want=%h", c, bus.mem_wdata, d_wd); end
            n_cmp++; if ({bus.if_rvalid, bus.if_err, bus.d_rvalid, bus.d_err} !== {e_if_rv, e_if_err, e_d_rv, e_d_err}) begin n_bad++; $display("FAIL rnd_flags c=%0d got=%b want=%b", c, {bus.if_rvalid, bus.if_err, bus.d_rvalid, bus.d_err}, {e_if_rv, e_if_err, e_d_rv, e_d_err}); end
            n_cmp++; if (bus.if_rdata !== (e_if_rv ? e_if_data : hold_if)) begin n_bad++; $display("FAIL rnd_if_rdata c=%0d got=%h want=%h", c, bus.if_rdata, e_if_rv ? e_if_data : hold_if); end
            n_cmp++; if (bus.d_rdata !== (e_d_rv ? e_d_data : hold_d)) begin n_bad++; $display("FAIL rnd_d_rdata c=%0d got=%h want=%h", c, bus.d_rdata, e_d_rv ? e_d_data : hold_d); end
            if (e_if_rv) hold_if = e_if_data;
            if (e_d_rv)  hold_d  = e_d_data;
            e_if_rv   = g_if && aligned;
            e_if_err  = g_if && !aligned;
            e_d_rv    = g_d && aligned && !d_wr;
            e_d_err   = g_d && !aligned;
            e_if_data = mem_fn(if_a);
            e_d_data  = mem_fn(d_a);
            if (g_if || g_d) pref_data = g_if;
            if (g_if) pend_if = 1'b0;
            if (g_d)  pend_d  = 1'b0;
            tick();
        end
        drive_idle();
    endtask

    initial begin
        drive_idle();
        reset = 1'b1;
        test_reset();
        test_single_fetch();
        test_conflict();
        test_store();
        test_misaligned();
        test_back_to_back();
        test_reset_mid_read();
        test_random(400);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
